// File: rtl/bsg_cache_amo_exec_pkg.sv
// Shared types and constants for the cache AMO execution path: opcodes,
// AMO sub-operations, operand size, support-level masks and a legality helper.
package bsg_cache_amo_exec_pkg;

  typedef enum logic [5:0] {
    LB        = 6'b000000,
    LH        = 6'b000001,
    LW        = 6'b000010,
    LD        = 6'b000011,
    LBU       = 6'b000100,
    LHU       = 6'b000101,
    LWU       = 6'b000110,
    LDU       = 6'b000111,
    SB        = 6'b001000,
    SH        = 6'b001001,
    SW        = 6'b001010,
    SD        = 6'b001011,
    AMOSWAP_W = 6'b100000,
    AMOADD_W  = 6'b100001,
    AMOXOR_W  = 6'b100010,
    AMOAND_W  = 6'b100011,
    AMOOR_W   = 6'b100100,
    AMOMIN_W  = 6'b100101,
    AMOMAX_W  = 6'b100110,
    AMOMINU_W = 6'b100111,
    AMOMAXU_W = 6'b101000,
    AMOSWAP_D = 6'b110000,
    AMOADD_D  = 6'b110001,
    AMOXOR_D  = 6'b110010,
    AMOAND_D  = 6'b110011,
    AMOOR_D   = 6'b110100,
    AMOMIN_D  = 6'b110101,
    AMOMAX_D  = 6'b110110,
    AMOMINU_D = 6'b110111,
    AMOMAXU_D = 6'b111000
  } bsg_cache_opcode_e;

  typedef enum logic [3:0] {
    e_cache_amo_swap = 4'd0,
    e_cache_amo_add  = 4'd1,
    e_cache_amo_xor  = 4'd2,
    e_cache_amo_and  = 4'd3,
    e_cache_amo_or   = 4'd4,
    e_cache_amo_min  = 4'd5,
    e_cache_amo_max  = 4'd6,
    e_cache_amo_minu = 4'd7,
    e_cache_amo_maxu = 4'd8
  } bsg_cache_amo_subop_e;

  typedef enum logic {
    e_amo_w = 1'b0,
    e_amo_d = 1'b1
  } bsg_cache_amo_size_e;

  localparam logic [8:0] amo_support_level_none_lp       = 9'b0_0000_0000;
  localparam logic [8:0] amo_support_level_swap_lp       = 9'b0_0000_0001;
  localparam logic [8:0] amo_support_level_logical_lp    = 9'b0_0001_1101;
  localparam logic [8:0] amo_support_level_arithmetic_lp = 9'b1_1111_1111;

  // Sub-op codes above maxu fall into the zero padding and are never legal.
  function automatic logic amo_subop_legal(input logic [3:0] subop, input logic [8:0] support);
    logic [15:0] padded;
    padded = {7'b0, support};
    return padded[subop];
  endfunction

endpackage

// File: rtl/bsg_cache_amo_alu.sv
// Combinational AMO arithmetic: computes the value written back to memory
// from the old memory value and the request operand.
module bsg_cache_amo_alu
  import bsg_cache_amo_exec_pkg::*;
#(
  parameter int width_p = 64
) (
  input  logic [3:0]         subop,
  input  logic [width_p-1:0] old,
  input  logic [width_p-1:0] operand,
  output logic [width_p-1:0] new_data
);

  // Sub-op select; on equal compare the old value is kept.
  always_comb begin
    new_data = operand;
    case (subop)
      e_cache_amo_swap: new_data = operand;
      e_cache_amo_add:  new_data = old + operand;
      e_cache_amo_xor:  new_data = old ^ operand;
      e_cache_amo_and:  new_data = old & operand;
      e_cache_amo_or:   new_data = old | operand;
      e_cache_amo_min:  new_data = ($signed(operand) < $signed(old)) ? operand : old;
      e_cache_amo_max:  new_data = ($signed(old) < $signed(operand)) ? operand : old;
      e_cache_amo_minu: new_data = (operand < old) ? operand : old;
      e_cache_amo_maxu: new_data = (old < operand) ? operand : old;
      default:          new_data = operand;
    endcase
  end

endmodule

// File: rtl/bsg_cache_amo_exec.sv
// Two-stage AMO execution engine. Stage 1 holds the request; the result is
// computed against mem_data_i (or the stage-2 write for a same-word follower)
// and registered into stage 2, which drives the outputs until yumi_i.
module bsg_cache_amo_exec
  import bsg_cache_amo_exec_pkg::*;
#(
  parameter int         data_width_p  = 64,
  parameter int         addr_width_p  = 32,
  parameter logic [8:0] amo_support_p = amo_support_level_arithmetic_lp
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [5:0]                opcode_i,
  input  logic [addr_width_p-1:0]   addr_i,
  input  logic [data_width_p-1:0]   operand_i,
  input  logic [data_width_p-1:0]   mem_data_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [data_width_p-1:0]   result_o,
  output logic [data_width_p-1:0]   wdata_o,
  output logic [data_width_p/8-1:0] wmask_o,
  output logic                      err_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int word_lsb_lp   = $clog2(mask_width_lp);
  localparam int word_width_lp = addr_width_p - word_lsb_lp;

  logic                      s1_v, s2_v, s2_adv, accept;
  logic [5:0]                s1_opcode;
  logic [addr_width_p-1:0]   s1_addr;
  logic [data_width_p-1:0]   s1_operand;
  logic                      s2_err;
  logic [data_width_p-1:0]   s2_result, s2_wdata;
  logic [mask_width_lp-1:0]  s2_wmask;
  logic [word_width_lp-1:0]  s1_word, s2_word;

  logic                      fwd, is_d, legal, lane_hi, zext;
  logic [3:0]                subop;
  bsg_cache_amo_size_e       size;
  logic [data_width_p-1:0]   eff;
  logic [63:0]               eff64, operand64, alu_old, alu_operand, new64, res64, wd64;
  logic [31:0]               old32, op32;
  logic [7:0]                mask8;
  logic                      unused_addr_bits;

  assign s2_adv      = s1_v & (~s2_v | yumi_i);
  assign ready_and_o = ~s1_v | s2_adv;
  assign accept      = v_i & ready_and_o;

  assign s1_word = s1_addr[addr_width_p-1:word_lsb_lp];
  assign fwd     = s2_v & ~s2_err & yumi_i & (s1_word == s2_word);

  assign subop   = s1_opcode[3:0];
  assign size    = bsg_cache_amo_size_e'(s1_opcode[4]);
  assign is_d    = (size == e_amo_d);
  assign legal   = s1_opcode[5] & amo_subop_legal(subop, amo_support_p)
                   & ~(is_d & (data_width_p == 32));
  assign lane_hi = (data_width_p == 64) & s1_addr[2] & ~is_d;
  assign zext    = (subop == e_cache_amo_minu) | (subop == e_cache_amo_maxu);
  assign unused_addr_bits = ^s1_addr[1:0];

  // Effective old word: bytes just written by the departing stage-2 op win.
  always_comb begin
    eff = mem_data_i;
    for (int b = 0; b < mask_width_lp; b++) begin
      if (fwd & s2_wmask[b]) eff[8*b +: 8] = s2_wdata[8*b +: 8];
    end
  end

  // Lane extraction and 32-bit widening; unsigned compares need zero-extension.
  always_comb begin
    eff64       = 64'(eff);
    operand64   = 64'(s1_operand);
    old32       = lane_hi ? eff64[63:32] : eff64[31:0];
    op32        = operand64[31:0];
    alu_old     = is_d ? eff64 : (zext ? {32'b0, old32} : {{32{old32[31]}}, old32});
    alu_operand = is_d ? operand64 : (zext ? {32'b0, op32} : {{32{op32[31]}}, op32});
    res64       = is_d ? eff64 : {{32{old32[31]}}, old32};
    wd64        = is_d ? new64 : {new64[31:0], new64[31:0]};
    mask8       = is_d ? 8'hFF : (lane_hi ? 8'hF0 : 8'h0F);
  end

  bsg_cache_amo_alu #(.width_p(64)) alu (
    .subop    (subop),
    .old      (alu_old),
    .operand  (alu_operand),
    .new_data (new64)
  );

  // Stage 1: capture an accepted request, empty when it moves to stage 2.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v       <= 1'b0;
      s1_opcode  <= '0;
      s1_addr    <= '0;
      s1_operand <= '0;
    end else if (accept) begin
      s1_v       <= 1'b1;
      s1_opcode  <= opcode_i;
      s1_addr    <= addr_i;
      s1_operand <= operand_i;
    end else if (s2_adv) begin
      s1_v       <= 1'b0;
    end
  end

  // Stage 2: register computed outputs; hold until the consumer takes them.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s2_v      <= 1'b0;
      s2_err    <= 1'b0;
      s2_result <= '0;
      s2_wdata  <= '0;
      s2_wmask  <= '0;
      s2_word   <= '0;
    end else if (s2_adv) begin
      s2_v      <= 1'b1;
      s2_err    <= ~legal;
      s2_result <= legal ? data_width_p'(res64) : '0;
      s2_wdata  <= legal ? data_width_p'(wd64) : '0;
      s2_wmask  <= legal ? mask_width_lp'(mask8) : '0;
      s2_word   <= s1_word;
    end else if (yumi_i) begin
      s2_v      <= 1'b0;
    end
  end

  assign v_o      = s2_v;
  assign err_o    = s2_err;
  assign result_o = s2_result;
  assign wdata_o  = s2_wdata;
  assign wmask_o  = s2_wmask;

endmodule
